// File: rtl/register_32_bits.sv
// General-purpose data register with load enable and asynchronous clear.
// Serves as the storage element for register-file entries and for pipeline
// or temporary registers. Q comes straight from the storage flops.
// Until Clr has been asserted, Q is undefined.
module register_32_bits #(
  parameter int               WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  output logic [WIDTH-1:0] Q,
  input  logic [WIDTH-1:0] D,
  input  logic             Clk,
  input  logic             Clr,
  input  logic             Le
);

  // Clear wins over load, even at the same edge. A load captures D on the rising edge.
  always_ff @(posedge Clk or posedge Clr) begin
    if (Clr)
      Q <= RESET_VALUE;
    else if (Le)
      Q <= D;
  end

endmodule

// File: tb/tb_register_32_bits.sv
// Self-checking bench for register_32_bits. Table-driven vectors and
// hand-written asynchronous-clear sequences feed a scoreboard queue.
module tb_register_32_bits;

  logic        clk = 1'b0;
  logic        clr;
  logic        le;
  logic [31:0] d;
  logic [31:0] q;

  register_32_bits #(.WIDTH(32), .RESET_VALUE(32'h0000_0000)) dut (
    .Q  (q),
    .D  (d),
    .Clk(clk),
    .Clr(clr),
    .Le (le)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        clr;
    logic        le;
    logic [31:0] d;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    int          id;
    logic [31:0] exp;
  } sb_t;

  vec_t vecs[$];
  sb_t  sb[$];
  int   checks = 0;
  int   passes = 0;

  task automatic compare(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic sb_check(input logic [31:0] act);
    sb_t e;
    if (sb.size() == 0) begin
      checks++;
      $display("FAIL scoreboard_empty: got %h expected <entry>", act);
    end else begin
      e = sb.pop_front();
      compare($sformatf("vec%0d", e.id), act, e.exp);
    end
  endtask

  // Apply vectors [lo, hi). Inputs change at the falling edge, and Q is sampled 1 ns after the rising edge.
  task automatic run_vecs(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      @(negedge clk);
      clr = vecs[i].clr;
      le  = vecs[i].le;
      d   = vecs[i].d;
      sb.push_back('{id: i, exp: vecs[i].exp});
      @(posedge clk);
      #1;
      sb_check(q);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] model;
    logic        r_le;
    logic [31:0] r_d;

    // Vectors 0-5: clear release, basic load, then hold while D changes, then reload.
    vecs.push_back('{1'b0, 1'b0, 32'h5555_5555, 32'h0000_0000});
    vecs.push_back('{1'b0, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA});
    vecs.push_back('{1'b0, 1'b0, 32'h1111_1111, 32'hAAAA_AAAA});
    vecs.push_back('{1'b0, 1'b0, 32'hABCD_EF78, 32'hAAAA_AAAA});
    vecs.push_back('{1'b0, 1'b0, 32'hABCD_EF78, 32'hAAAA_AAAA});
    vecs.push_back('{1'b0, 1'b1, 32'hABCD_EF78, 32'hABCD_EF78});
    // Vectors 6-11: clear dominates load, release holds zero, then the first load.
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b1, 1'b1, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0000_0000});
    vecs.push_back('{1'b0, 1'b1, 32'h1357_9BDF, 32'h1357_9BDF});
    // Vectors 12-14: continuous load with D changing mid-cycle, then hold.
    vecs.push_back('{1'b0, 1'b1, 32'h7777_7777, 32'h7777_7777});
    vecs.push_back('{1'b0, 1'b1, 32'hAAAA_AAAA, 32'hAAAA_AAAA});
    vecs.push_back('{1'b0, 1'b0, 32'h5555_5555, 32'hAAAA_AAAA});

    clr = 1'b1;
    le  = 1'b0;
    d   = 32'h0000_0000;
    @(posedge clk);
    #1;
    compare("reset", q, 32'h0000_0000);

    run_vecs(0, 6);

    // A change on D between edges must not pass through to Q.
    #2;
    d = 32'hDEAD_BEEF;
    le = 1'b1;
    #1;
    compare("no_transparency", q, 32'hABCD_EF78);
    le = 1'b0;

    // Raising the clear between edges must take effect without a clock edge.
    #1;
    clr = 1'b1;
    #1;
    compare("async_clear", q, 32'h0000_0000);

    run_vecs(6, 15);

    // Assert clear just before a load edge and release it just after the edge.
    @(negedge clk);
    le = 1'b1;
    d  = 32'h1234_5678;
    #4;
    clr = 1'b1;
    #0.5;
    compare("clr_before_edge", q, 32'h0000_0000);
    @(posedge clk);
    #1;
    clr = 1'b0;
    compare("clr_across_edge", q, 32'h0000_0000);
    @(negedge clk);
    #1;
    compare("after_clr_release", q, 32'h0000_0000);
    @(posedge clk);
    #1;
    compare("load_after_clr", q, 32'h1234_5678);

    // Random loads and holds, checked against a reference model of the register.
    model = 32'h1234_5678;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      r_le = 1'($urandom_range(0, 1));
      r_d  = $urandom;
      le = r_le;
      d  = r_d;
      if (r_le) model = r_d;
      sb.push_back('{id: 100 + i, exp: model});
      @(posedge clk);
      #1;
      sb_check(q);
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
